// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between two requesters.
// Each access runs LATENCY strobe cycles, then a one-cycle registered response.
module dmem_arbiter #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    input  logic [31:0] mem_readData,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  req_q, req_d;
    logic        last_q, last_d;
    logic        own_q, own_d;
    logic        we_q, we_d;
    logic        oor_q, oor_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        gnt;
    logic [31:0] sel_addr;
    logic        sel_in;

    always_comb begin
        gnt      = (req_q == 2'b11) ? ~last_q : req_q[1];
        sel_addr = gnt ? p1_addr : p0_addr;
        sel_in   = sel_addr[31:2] < DEPTH_W;
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = 2'b00;
        last_d   = last_q;
        own_d    = own_q;
        we_d     = we_q;
        oor_d    = oor_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 2'b00;
        err_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            IDLE: begin
                // Requests are registered first so the grant never depends
                // on a req that arrived in the same cycle.
                req_d = {p1_req, p0_req};
                if (req_q != 2'b00) begin
                    req_d   = 2'b00;
                    own_d   = gnt;
                    last_d  = gnt;
                    we_d    = gnt ? p1_we : p0_we;
                    addr_d  = sel_addr & ~32'h3;
                    wdata_d = gnt ? p1_wdata : p0_wdata;
                    oor_d   = ~sel_in;
                    if (sel_in) begin
                        state_d = ACCESS;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = RESP;
                        ack_d[gnt] = 1'b1;
                        err_d[gnt] = 1'b1;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    ack_d[own_q] = 1'b1;
                    err_d[own_q] = oor_q;
                    if (!we_q) begin
                        if (own_q) rdata1_d = mem_readData;
                        else       rdata0_d = mem_readData;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            req_q    <= 2'b00;
            last_q   <= 1'b1;
            own_q    <= 1'b0;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            ack_q    <= 2'b00;
            err_q    <= 2'b00;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            last_q   <= last_d;
            own_q    <= own_d;
            we_q     <= we_d;
            oor_q    <= oor_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign p0_ack        = ack_q[0];
    assign p1_ack        = ack_q[1];
    assign p0_err        = err_q[0];
    assign p1_err        = err_q[1];
    assign p0_rdata      = rdata0_q;
    assign p1_rdata      = rdata1_q;
    assign mem_address   = addr_q;
    assign mem_writeData = wdata_q;
    assign mem_memRead   = (state_q == ACCESS) & ~we_q;
    assign mem_memWrite  = (state_q == ACCESS) & we_q;
    assign busy          = state_q != IDLE;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (LATENCY 1 and 4) with behavioural
// memories, checked cycle by cycle against a transaction-level model.
module tb_dmem_arbiter;

    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        p0_req   [2];
    logic        p0_we    [2];
    logic [31:0] p0_addr  [2];
    logic [31:0] p0_wdata [2];
    logic        p0_ack   [2];
    logic        p0_err   [2];
    logic [31:0] p0_rdata [2];
    logic        p1_req   [2];
    logic        p1_we    [2];
    logic [31:0] p1_addr  [2];
    logic [31:0] p1_wdata [2];
    logic        p1_ack   [2];
    logic        p1_err   [2];
    logic [31:0] p1_rdata [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wd     [2];
    logic        m_rd     [2];
    logic        m_wr     [2];
    logic [31:0] m_rdata  [2];
    logic        busy     [2];

    dmem_arbiter #(.LATENCY(1), .DEPTH(DEPTH)) u_l1 (
        .clk(clk), .rst(rst[0]),
        .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]),
        .p0_wdata(p0_wdata[0]), .p0_ack(p0_ack[0]), .p0_err(p0_err[0]),
        .p0_rdata(p0_rdata[0]),
        .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]),
        .p1_wdata(p1_wdata[0]), .p1_ack(p1_ack[0]), .p1_err(p1_err[0]),
        .p1_rdata(p1_rdata[0]),
        .mem_address(m_addr[0]), .mem_writeData(m_wd[0]),
        .mem_memRead(m_rd[0]), .mem_memWrite(m_wr[0]),
        .mem_readData(m_rdata[0]), .busy(busy[0])
    );

    dmem_arbiter #(.LATENCY(4), .DEPTH(DEPTH)) u_l4 (
        .clk(clk), .rst(rst[1]),
        .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]),
        .p0_wdata(p0_wdata[1]), .p0_ack(p0_ack[1]), .p0_err(p0_err[1]),
        .p0_rdata(p0_rdata[1]),
        .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]),
        .p1_wdata(p1_wdata[1]), .p1_ack(p1_ack[1]), .p1_err(p1_err[1]),
        .p1_rdata(p1_rdata[1]),
        .mem_address(m_addr[1]), .mem_writeData(m_wd[1]),
        .mem_memRead(m_rd[1]), .mem_memWrite(m_wr[1]),
        .mem_readData(m_rdata[1]), .busy(busy[1])
    );

    logic [31:0] mem [2][DEPTH] = '{default: '0};
    assign m_rdata[0] = mem[0][m_addr[0][6:2]];
    assign m_rdata[1] = mem[1][m_addr[1][6:2]];
    always @(negedge clk)
        for (int d = 0; d < 2; d++)
            if (m_wr[d]) mem[d][m_addr[d][6:2]] <= m_wd[d];

    int          lat [2] = '{1, 4};
    logic [31:0] refm [2][DEPTH];
    logic [31:0] exp_rd [2][2];
    logic        last_g [2];
    logic        tw [2];
    logic [31:0] ta [2];
    logic [31:0] td [2];
    int          total = 0;
    int          passed = 0;
    int          cur_d = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s dut=%0d got=%h want=%h", tag, cur_d, obs, exp);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 2) < DEPTH;
    endfunction

    // Raise the requests in mask m, then follow the expected schedule.
    task automatic run(input int d, input logic [1:0] m);
        int ord [2];
        int st [3];
        int ak [2];
        int n;
        int p;
        logic [1:0] ea;
        logic er, ew, eb;
        cur_d = d;
        @(negedge clk);
        p0_req[d] = m[0]; p0_we[d] = tw[0];
        p0_addr[d] = ta[0]; p0_wdata[d] = td[0];
        p1_req[d] = m[1]; p1_we[d] = tw[1];
        p1_addr[d] = ta[1]; p1_wdata[d] = td[1];
        if (m == 2'b11) begin
            ord[0] = last_g[d] ? 0 : 1;
            ord[1] = 1 - ord[0];
            n = 2;
        end else begin
            ord[0] = m[1] ? 1 : 0;
            ord[1] = 0;
            n = 1;
        end
        st[0] = 0;
        for (int i = 0; i < n; i++) begin
            ak[i] = st[i] + (in_rng(ta[ord[i]]) ? lat[d] + 2 : 2);
            st[i+1] = ak[i] + 1;
        end
        for (int k = 1; k <= ak[n-1] + 1; k++) begin
            @(negedge clk);
            ea = 2'b00; er = 1'b0; ew = 1'b0; eb = 1'b0;
            for (int i = 0; i < n; i++) begin
                p = ord[i];
                if (k >= st[i] + 2 && k <= ak[i]) eb = 1'b1;
                if (in_rng(ta[p]) && k >= st[i] + 2 &&
                    k <= st[i] + lat[d] + 1) begin
                    er = !tw[p];
                    ew = tw[p];
                    chk("mem_address", m_addr[d], ta[p] & ~32'h3);
                    if (tw[p]) chk("mem_writeData", m_wd[d], td[p]);
                end
                if (k == ak[i]) begin
                    ea[p] = 1'b1;
                    if (in_rng(ta[p])) begin
                        if (tw[p]) refm[d][ta[p][6:2]] = td[p];
                        else exp_rd[d][p] = refm[d][ta[p][6:2]];
                    end
                    if (p == 0) begin
                        chk("p0_err", p0_err[d], !in_rng(ta[p]));
                        p0_req[d] = 1'b0;
                    end else begin
                        chk("p1_err", p1_err[d], !in_rng(ta[p]));
                        p1_req[d] = 1'b0;
                    end
                    last_g[d] = (p == 1);
                end
            end
            chk("mem_memRead", m_rd[d], er);
            chk("mem_memWrite", m_wr[d], ew);
            chk("busy", busy[d], eb);
            chk("p0_ack", p0_ack[d], ea[0]);
            chk("p1_ack", p1_ack[d], ea[1]);
            chk("p0_rdata", p0_rdata[d], exp_rd[d][0]);
            chk("p1_rdata", p1_rdata[d], exp_rd[d][1]);
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [31:0] a,
                            input logic [31:0] v);
        tw[p] = w; ta[p] = a; td[p] = v;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            p0_req[d] = 0; p0_we[d] = 0; p0_addr[d] = 0; p0_wdata[d] = 0;
            p1_req[d] = 0; p1_we[d] = 0; p1_addr[d] = 0; p1_wdata[d] = 0;
            last_g[d] = 1'b1;
            exp_rd[d][0] = 0; exp_rd[d][1] = 0;
            for (int w = 0; w < DEPTH; w++) refm[d][w] = 0;
        end
        for (int p = 0; p < 2; p++) set_port(p, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            cur_d = d;
            chk("rst_ack", {p1_ack[d], p0_ack[d]}, 0);
            chk("rst_err", {p1_err[d], p0_err[d]}, 0);
            chk("rst_p0_rdata", p0_rdata[d], 0);
            chk("rst_p1_rdata", p1_rdata[d], 0);
            chk("rst_strobes", {m_rd[d], m_wr[d]}, 0);
            chk("rst_mem_address", m_addr[d], 0);
            chk("rst_mem_writeData", m_wd[d], 0);
            chk("rst_busy", busy[d], 0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        // LATENCY 1 write then readback
        set_port(0, 1, 32'h8, 32'hDEADBEEF);
        run(0, 2'b01);
        set_port(0, 0, 32'h8, 0);
        run(0, 2'b01);

        // tie from reset: port 0 first, then port 1, then port 0 again
        set_port(0, 0, 32'h4, 0);
        set_port(1, 1, 32'h4, 32'h12345678);
        run(1, 2'b11);
        set_port(0, 0, 32'h4, 0);
        run(1, 2'b01);

        // last valid word with wait states
        set_port(1, 0, 32'h7C, 0);
        run(1, 2'b10);

        // out-of-range write must not alias onto word 0
        set_port(0, 1, 32'h0, 32'h11111111);
        run(0, 2'b01);
        set_port(0, 1, 32'h80, 32'hBADBAD00);
        run(0, 2'b01);
        set_port(0, 0, 32'h0, 0);
        run(0, 2'b01);

        // reset during the second ACCESS cycle
        cur_d = 1;
        @(negedge clk);
        p0_req[1] = 1'b1; p0_we[1] = 1'b0; p0_addr[1] = 32'h10;
        repeat (3) @(negedge clk);
        chk("mid_memRead", m_rd[1], 1);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("abort_strobes", {m_rd[1], m_wr[1]}, 0);
        chk("abort_busy", busy[1], 0);
        chk("abort_ack", {p1_ack[1], p0_ack[1]}, 0);
        rst[1] = 1'b0;
        p0_req[1] = 1'b0;
        last_g[1] = 1'b1;
        exp_rd[1][0] = 0; exp_rd[1][1] = 0;
        @(negedge clk);
        chk("abort_no_ack", {p1_ack[1], p0_ack[1]}, 0);
        set_port(0, 0, 32'h7C, 0);
        set_port(1, 1, 32'h10, 32'h0BADF00D);
        run(1, 2'b11);

        // misaligned address is forced to its word
        set_port(1, 1, 32'h0B, 32'hA5A5A5A5);
        run(0, 2'b10);
        set_port(1, 0, 32'h08, 0);
        run(0, 2'b10);

        for (int it = 0; it < 60; it++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 7) == 0)
                    set_port(p, 1'($urandom), $urandom | 32'h80, $urandom);
                else
                    set_port(p, 1'($urandom),
                             ($urandom_range(0, DEPTH - 1) << 2) |
                             ($urandom & 32'h3), $urandom);
            end
            run(int'($urandom_range(0, 1)), 2'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller that shares the single-port data memory between port 0 (MEM-stage load/store) and port 1 (debug/DMA loader).
- Arbitrates round-robin and sequences each access through a programmable number of wait-state cycles.
- Range-checks word addresses and returns a registered read word with a one-cycle acknowledge pulse.
- Sits between the requesters and the memory's address/writeData/memRead/memWrite/readData interface.

Parameters:
- LATENCY, 1, number of cycles the memory strobes are held per access (legal range 1..15).
- DEPTH, 32, number of 32-bit words in the memory; byte addresses with (addr>>2) >= DEPTH are out of range.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held high with fields stable until p0_ack.
- p0_we  in  1  port 0 direction: 1 = write, 0 = read.
- p0_addr  in  32  port 0 byte address; bits [1:0] are ignored.
- p0_wdata  in  32  port 0 write data.
- p0_ack  out  1  one-cycle completion pulse for port 0.
- p0_err  out  1  valid with p0_ack; 1 = address out of range.
- p0_rdata  out  32  port 0 read result; updated only at a port 0 read ack, held otherwise.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1.
- mem_address  out  32  address to memory.
- mem_writeData  out  32  write data to memory.
- mem_memRead  out  1  memory read strobe.
- mem_memWrite  out  1  memory write strobe.
- mem_readData  in  32  combinational read data from memory.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst high at posedge, takes priority over everything):
  - state = IDLE, wait counter = 0, last_grant = 1.
  - p0_ack = p1_ack = 0, p0_err = p1_err = 0, p0_rdata = p1_rdata = 0.
  - owner/addr/wdata/we latches cleared to 0.
  - Memory outputs: mem_memRead = mem_memWrite = 0, mem_address = mem_writeData = 0.
- Reset mid-access aborts the transaction:
  - No ack is issued.
  - Strobes drop in the cycle after the reset edge.
  - The requester must reissue.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If no req, stay.
  - If exactly one req, grant it.
  - If both req, grant the port != last_grant, so port 0 wins the first tie after reset.
  - At the grant edge, latch owner, we, addr (with [1:0] forced to 0), wdata and range flag, and set last_grant = owner.
  - If in range: go to ACCESS with counter = LATENCY-1.
  - If out of range: go to RESP directly, and the memory is never strobed.
- ACCESS:
  - Outputs: mem_address = latched addr, mem_writeData = latched wdata, mem_memWrite = we, mem_memRead = !we, held constant for LATENCY cycles.
  - Repeated negedge writes of the same data are idempotent.
  - Counter decrements each cycle.
  - At the edge where counter == 0: if read, capture mem_readData into owner's rdata; go to RESP.
- RESP:
  - Owner's ack = 1 for exactly this cycle; err = range flag.
  - Memory strobes are 0.
  - An out-of-range read leaves rdata unchanged.
  - Next state is always IDLE.
  - A req still high during RESP is not sampled; it is sampled again in IDLE as a new transaction.
- Outputs:
  - ack, err and rdata are registered.
  - All mem_* outputs are decoded from registered state only, with no combinational path from req.
  - Strobes are 0 outside ACCESS.
- Timing:
  - Req to ack latency: LATENCY+2 cycles in range, 2 cycles out of range, both measured from the IDLE sampling edge.
  - Throughput: one access per LATENCY+3 cycles, because IDLE is re-entered for arbitration.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1,...
- The non-owner's ack, err and rdata never change during another port's transaction.
- A req dropped before ack is a protocol violation; the latched transaction still completes.

Test Plan:
- Reset then write/read: p0 write addr 0x8, data 0xDEADBEEF, LATENCY=1 → mem_memWrite high 1 cycle with mem_address=0x8, p0_ack 3 cycles after the sampling edge; then p0 read 0x8 → p0_rdata=0xDEADBEEF, p0_err=0.
- Simultaneous requests from reset: p0 read 0x4, p1 write 0x4 = 0x12345678 → p0 granted first and reads 0; then p1 acks; a following p0 read returns 0x12345678; grant order 0,1,0.
- Wait states: LATENCY=4, p1 read 0x7C (word 31, last valid) → mem_memRead high exactly 4 consecutive cycles, p1_ack 6 cycles after the sampling edge, busy high throughout.
- Out of range: DEPTH=32, p0 write 0x80 → no mem strobe ever, p0_ack and p0_err both high 2 cycles after sampling, memory contents unchanged on readback.
- Reset mid-access: LATENCY=4, assert rst during the 2nd ACCESS cycle → no ack, strobes 0 from the next cycle, busy=0; then both ports request → port 0 granted first.
- Misaligned address: p1 write 0x0B = 0xA5A5A5A5, then p1 read 0x08 → p1_rdata=0xA5A5A5A5; during both accesses mem_address=0x08.
